adc0809_ctrl: RTL and testbench
===============================

ADC0809_CTRL -- requirements
Module: adc0809_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25; AD_CLK toggles every CLK_DIV CLK cycles.
REQ-002 SHALL have parameter SETUP_CYC, default 2; AD_ADDR setup cycles before ALE/START.
REQ-003 SHALL have parameter PULSE_CYC, default 5; ALE/START high width in CLK cycles.
REQ-004 SHALL have parameter OE_CYC, default 3; AD_OE high width in CLK cycles.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 10000; maximum EOC wait in CLK cycles.
REQ-006 SHALL have these ports, in this order:
- CLK  in  1  system clock.
- RSTn  in  1  reset; asynchronous, active-low.
- Start_Req  in  1  conversion request, sampled in IDLE.
- Chan  in  3  ADC input channel for the request.
- AD_EOC  in  1  end-of-conversion from ADC, asynchronous.
- AD_Data  in  8  ADC parallel data bus.
- AD_CLK  out  1  ADC conversion clock.
- AD_ADDR  out  3  ADC channel address.
- AD_ALE  out  1  address latch enable.
- AD_START  out  1  conversion start.
- AD_OE  out  1  ADC output enable.
- Sample_Data  out  8  last captured conversion result.
- Sample_Valid  out  1  one-cycle pulse, new Sample_Data.
- Busy  out  1  high whenever state is not IDLE.
- Timeout  out  1  one-cycle pulse, EOC wait aborted.

Function
REQ-007 SHALL generate AD_CLK from a free-running divider independent of the FSM: CLK_DIV-1 wrap, 50% duty.
REQ-008 SHALL synchronize AD_EOC through two CLK flops before use; all EOC decisions use the synchronized value.
REQ-009 SHALL implement states IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI, READ, DONE.
REQ-010 IDLE: when Start_Req=1, SHALL latch Chan into AD_ADDR and enter SETUP next cycle; Start_Req=0 stays IDLE.
REQ-011 SETUP: SHALL hold AD_ALE=AD_START=0 for SETUP_CYC cycles, then enter PULSE.
REQ-012 PULSE: SHALL drive AD_ALE=AD_START=1 for exactly PULSE_CYC cycles, then enter WAIT_LO with timeout counter cleared.
REQ-013 WAIT_LO: SHALL wait for synchronized EOC=0, then enter WAIT_HI; counter keeps running (not cleared).
REQ-014 WAIT_HI: SHALL wait for synchronized EOC=1, then enter READ.
REQ-015 Timeout counter SHALL increment each cycle in WAIT_LO/WAIT_HI; on reaching TIMEOUT_CYC, SHALL pulse Timeout for one cycle, return to IDLE, leave Sample_Data unchanged, no Sample_Valid.
REQ-016 READ: SHALL drive AD_OE=1 for exactly OE_CYC cycles and capture AD_Data into Sample_Data on the last READ cycle.
REQ-017 DONE: SHALL pulse Sample_Valid for exactly one cycle (the cycle after the last READ cycle), AD_OE=0, then return to IDLE.
REQ-018 AD_ADDR SHALL stay constant from latch until the next accepted request; Chan changes while Busy=1 SHALL be ignored.
REQ-019 Start_Req while Busy=1 SHALL be ignored (no queuing); Start_Req held high SHALL start a new conversion on the cycle after DONE/timeout (back-to-back).
REQ-020 AD_ALE, AD_START, AD_OE SHALL be registered outputs, glitch-free, never high simultaneously with each other except ALE with START.
REQ-021 All phase counters SHALL be wide enough for their parameter, no wrap within one phase.

Reset
REQ-022 RSTn=0 SHALL immediately force state IDLE, AD_CLK=0, divider=0, AD_ADDR=0, AD_ALE=AD_START=AD_OE=0, Sample_Data=0x00, Sample_Valid=0, Busy=0, Timeout=0, EOC synchronizer=1.
REQ-023 Reset mid-conversion SHALL abort with no Sample_Valid; first request after release SHALL run a full sequence.

Verification
REQ-024 Default parameters, Chan=5, Start_Req 1 cycle, ADC model drops EOC 8 cycles after START falls, raises 100 cycles later, AD_Data=0xA7 -> AD_ADDR=5, ALE/START 5 cycles high, AD_OE 3 cycles, Sample_Data=0xA7, one Sample_Valid pulse, Busy low afterward.
REQ-025 EOC held high forever -> Timeout pulses once exactly TIMEOUT_CYC cycles after WAIT_LO entry, Sample_Data keeps 0x00, Busy falls.
REQ-026 Start_Req held high, Chan toggling 1/2, AD_Data 0x11 then 0x22 -> two back-to-back conversions, no idle gap beyond one IDLE cycle, results 0x11 then 0x22.
REQ-027 Start_Req pulses and Chan change during WAIT_HI -> ignored; AD_ADDR unchanged, single Sample_Valid.
REQ-028 RSTn asserted during READ -> AD_OE=0 immediately, no Sample_Valid, subsequent request completes with correct data.
REQ-029 AD_CLK period measured = 2*CLK_DIV CLK cycles, unaffected by FSM activity.

Source files
------------

// File: rtl/adc0809_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc0809_ctrl
// Brief    : ADC0809 conversion sequencer. Free-running ADC clock divider,
//            2-flop EOC synchronizer, and a sequencing FSM covering address
//            setup, ALE/START pulse, EOC handshake with timeout, and
//            OE-gated data capture.
// Revision : 1.0 - initial release
// ============================================================================
module adc0809_ctrl #(
  parameter int CLK_DIV     = 25,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 5,
  parameter int OE_CYC      = 3,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start_Req,
  input  logic [2:0] Chan,
  input  logic       AD_EOC,
  input  logic [7:0] AD_Data,
  output logic       AD_CLK,
  output logic [2:0] AD_ADDR,
  output logic       AD_ALE,
  output logic       AD_START,
  output logic       AD_OE,
  output logic [7:0] Sample_Data,
  output logic       Sample_Valid,
  output logic       Busy,
  output logic       Timeout
);

  // Counter widths sized from the parameters so no phase can wrap early.
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int PH_MAX = (SETUP_CYC > PULSE_CYC)
                          ? ((SETUP_CYC > OE_CYC) ? SETUP_CYC : OE_CYC)
                          : ((PULSE_CYC > OE_CYC) ? PULSE_CYC : OE_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_READ    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic              ad_clk_q;
  logic              eoc_meta_q;
  logic              eoc_sync_q;
  logic [PH_W-1:0]   ph_q;
  logic [TO_W-1:0]   tmo_q;
  logic [2:0]        addr_q;
  logic              ale_q;
  logic              start_q;
  logic              oe_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              timeout_q;

  // ADC clock: toggles every CLK_DIV cycles regardless of FSM activity.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      div_q    <= '0;
      ad_clk_q <= 1'b0;
    end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_q    <= '0;
      ad_clk_q <= ~ad_clk_q;
    end else begin
      div_q    <= div_q + DIV_W'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous EOC line; idles high.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      eoc_meta_q <= 1'b1;
      eoc_sync_q <= 1'b1;
    end else begin
      eoc_meta_q <= AD_EOC;
      eoc_sync_q <= eoc_meta_q;
    end
  end

  // Conversion sequencer with registered strobes and result capture.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      tmo_q     <= '0;
      addr_q    <= 3'd0;
      ale_q     <= 1'b0;
      start_q   <= 1'b0;
      oe_q      <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start_Req) begin
            addr_q  <= Chan;
            ph_q    <= '0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_q == PH_W'(SETUP_CYC - 1)) begin
            ph_q    <= '0;
            ale_q   <= 1'b1;
            start_q <= 1'b1;
            state_q <= ST_PULSE;
          end else begin
            ph_q    <= ph_q + PH_W'(1);
          end
        end
        ST_PULSE: begin
          if (ph_q == PH_W'(PULSE_CYC - 1)) begin
            ph_q    <= '0;
            ale_q   <= 1'b0;
            start_q <= 1'b0;
            tmo_q   <= '0;
            state_q <= ST_WAIT_LO;
          end else begin
            ph_q    <= ph_q + PH_W'(1);
          end
        end
        ST_WAIT_LO: begin
          // Timeout takes priority; the counter spans both wait states.
          if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TO_W'(1);
            if (!eoc_sync_q) begin
              state_q <= ST_WAIT_HI;
            end
          end
        end
        ST_WAIT_HI: begin
          if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TO_W'(1);
            if (eoc_sync_q) begin
              ph_q    <= '0;
              oe_q    <= 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          // Data is taken at the end of the last OE cycle, when the bus has settled longest.
          if (ph_q == PH_W'(OE_CYC - 1)) begin
            ph_q    <= '0;
            oe_q    <= 1'b0;
            data_q  <= AD_Data;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            ph_q    <= ph_q + PH_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          ale_q   <= 1'b0;
          start_q <= 1'b0;
          oe_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign AD_CLK       = ad_clk_q;
  assign AD_ADDR      = addr_q;
  assign AD_ALE       = ale_q;
  assign AD_START     = start_q;
  assign AD_OE        = oe_q;
  assign Sample_Data  = data_q;
  assign Sample_Valid = valid_q;
  assign Timeout      = timeout_q;
  assign Busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc0809_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc0809_ctrl
// Brief    : Self-checking bench for adc0809_ctrl with a behavioural ADC
//            EOC model, a vector table of single conversions and directed
//            multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc0809_ctrl;

  logic       CLK;
  logic       RSTn;
  logic       Start_Req;
  logic [2:0] Chan;
  logic       AD_EOC;
  logic [7:0] AD_Data;
  logic       AD_CLK;
  logic [2:0] AD_ADDR;
  logic       AD_ALE;
  logic       AD_START;
  logic       AD_OE;
  logic [7:0] Sample_Data;
  logic       Sample_Valid;
  logic       Busy;
  logic       Timeout;

  adc0809_ctrl dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Start_Req    (Start_Req),
    .Chan         (Chan),
    .AD_EOC       (AD_EOC),
    .AD_Data      (AD_Data),
    .AD_CLK       (AD_CLK),
    .AD_ADDR      (AD_ADDR),
    .AD_ALE       (AD_ALE),
    .AD_START     (AD_START),
    .AD_OE        (AD_OE),
    .Sample_Data  (Sample_Data),
    .Sample_Valid (Sample_Valid),
    .Busy         (Busy),
    .Timeout      (Timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit adc_en  = 1'b0;

  // ADC model: EOC drops 8 cycles after START falls, rises 100 cycles later.
  initial begin
    AD_EOC = 1'b1;
    forever begin
      @(negedge AD_START);
      if (adc_en) begin
        repeat (8) @(posedge CLK);
        #1 AD_EOC = 1'b0;
        repeat (100) @(posedge CLK);
        #1 AD_EOC = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Per-conversion measurements
  int         m_ale, m_start, m_oe, m_valid, m_tmo, m_overlap, m_addr_chg;
  logic [7:0] m_data;
  logic [2:0] m_addr;

  task automatic run_conv(input logic [2:0] ch, input logic [7:0] d);
    int budget;
    Chan = ch; AD_Data = d; Start_Req = 1'b1;
    tick();
    Start_Req = 1'b0;
    m_ale = 0; m_start = 0; m_oe = 0; m_valid = 0; m_tmo = 0;
    m_overlap = 0; m_addr_chg = 0; m_data = 8'h00; m_addr = AD_ADDR;
    budget = 0;
    while (Busy && budget < 3000) begin
      if (AD_ALE) m_ale++;
      if (AD_START) m_start++;
      if (AD_OE) m_oe++;
      if ((AD_ALE || AD_START) && AD_OE) m_overlap++;
      if (AD_ADDR != m_addr) m_addr_chg++;
      if (Timeout) m_tmo++;
      if (Sample_Valid) begin
        m_valid++;
        m_data = Sample_Data;
      end
      tick();
      budget++;
    end
    if (Timeout) m_tmo++;
    chk("conv_finished_in_budget", 32'(budget < 3000), 32'd1);
  endtask

  typedef struct {
    logic [2:0] chan;
    logic [7:0] data;
    logic [2:0] exp_addr;
    logic [7:0] exp_data;
    int         exp_pulse;
    int         exp_oe;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int         k;
    int         budget;
    int         n;
    int         gap;
    int         seen_valid;
    int         e;
    int         rise0, rise1, rise2, fall1;
    int         nrise;
    logic       prev_clk;
    logic [7:0] res[2];
    logic [2:0] addr2;

    vecs[0] = '{chan: 3'd5, data: 8'hA7, exp_addr: 3'd5, exp_data: 8'hA7, exp_pulse: 5, exp_oe: 3};
    vecs[1] = '{chan: 3'd0, data: 8'h00, exp_addr: 3'd0, exp_data: 8'h00, exp_pulse: 5, exp_oe: 3};
    vecs[2] = '{chan: 3'd7, data: 8'hFF, exp_addr: 3'd7, exp_data: 8'hFF, exp_pulse: 5, exp_oe: 3};
    vecs[3] = '{chan: 3'd2, data: 8'h3C, exp_addr: 3'd2, exp_data: 8'h3C, exp_pulse: 5, exp_oe: 3};

    RSTn = 1'b1; Start_Req = 1'b0; Chan = 3'd0; AD_Data = 8'h00;
    #3 RSTn = 1'b0;
    #1;
    // Reset state is forced asynchronously
    chk("rst_AD_CLK", 32'(AD_CLK), 32'd0);
    chk("rst_AD_ADDR", 32'(AD_ADDR), 32'd0);
    chk("rst_ALE_START_OE", {29'd0, AD_ALE, AD_START, AD_OE}, 32'd0);
    chk("rst_Sample_Data", 32'(Sample_Data), 32'h00);
    chk("rst_Valid_Busy_Timeout", {29'd0, Sample_Valid, Busy, Timeout}, 32'd0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    tick();

    // EOC never falls: timeout after TIMEOUT_CYC wait cycles
    adc_en = 1'b0;
    Chan = 3'd4; Start_Req = 1'b1;
    tick();
    Start_Req = 1'b0;
    budget = 0;
    while (!AD_START && budget < 100) begin tick(); budget++; end
    while (AD_START && budget < 100) begin tick(); budget++; end
    k = 0; seen_valid = 0;
    while (!Timeout && k < 12000) begin
      tick();
      k++;
      if (Sample_Valid) seen_valid++;
    end
    chk("timeout_latency", 32'(k), 32'd10000);
    chk("timeout_busy_low", 32'(Busy), 32'd0);
    chk("timeout_data_kept", 32'(Sample_Data), 32'h00);
    chk("timeout_no_valid", 32'(seen_valid), 32'd0);
    tick();
    chk("timeout_one_pulse", 32'(Timeout), 32'd0);
    adc_en = 1'b1;
    repeat (3) tick();

    // Table of single conversions
    for (int i = 0; i < 4; i++) begin
      run_conv(vecs[i].chan, vecs[i].data);
      chk($sformatf("v%0d_addr", i), 32'(m_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_addr_stable", i), 32'(m_addr_chg), 32'd0);
      chk($sformatf("v%0d_ale_cycles", i), 32'(m_ale), 32'(vecs[i].exp_pulse));
      chk($sformatf("v%0d_start_cycles", i), 32'(m_start), 32'(vecs[i].exp_pulse));
      chk($sformatf("v%0d_oe_cycles", i), 32'(m_oe), 32'(vecs[i].exp_oe));
      chk($sformatf("v%0d_no_overlap", i), 32'(m_overlap), 32'd0);
      chk($sformatf("v%0d_valid_pulses", i), 32'(m_valid), 32'd1);
      chk($sformatf("v%0d_valid_data", i), 32'(m_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_sample_data", i), 32'(Sample_Data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_no_timeout", i), 32'(m_tmo), 32'd0);
      chk($sformatf("v%0d_busy_low", i), 32'(Busy), 32'd0);
      repeat (2) tick();
    end

    // Back-to-back: Start_Req held, second request on channel 2
    Chan = 3'd1; AD_Data = 8'h11; Start_Req = 1'b1;
    tick();
    n = 0; gap = 0; budget = 0; addr2 = 3'd0;
    res[0] = 8'h00; res[1] = 8'h00;
    chk("b2b_addr1", 32'(AD_ADDR), 32'd1);
    while (n < 2 && budget < 3000) begin
      if (n == 1 && !Busy) gap++;
      if (n == 1 && AD_ALE) addr2 = AD_ADDR;
      if (Sample_Valid) begin
        res[n] = Sample_Data;
        n++;
        if (n == 1) begin
          Chan = 3'd2; AD_Data = 8'h22;
        end else begin
          Start_Req = 1'b0;
        end
      end
      tick();
      budget++;
    end
    chk("b2b_count", 32'(n), 32'd2);
    chk("b2b_res0", 32'(res[0]), 32'h11);
    chk("b2b_res1", 32'(res[1]), 32'h22);
    chk("b2b_idle_gap", 32'(gap), 32'd1);
    chk("b2b_addr2", 32'(addr2), 32'd2);
    tick();
    chk("b2b_no_third", 32'(Busy), 32'd0);
    repeat (2) tick();

    // Requests and channel changes during WAIT_HI are ignored
    Chan = 3'd3; AD_Data = 8'h5C; Start_Req = 1'b1;
    tick();
    Start_Req = 1'b0;
    e = 0; seen_valid = 0; k = 0; budget = 0;
    while (Busy && budget < 3000) begin
      if (AD_ADDR != 3'd3) k++;
      if (Sample_Valid) seen_valid++;
      if (!AD_EOC) begin
        e++;
        if (e == 5) begin Start_Req = 1'b1; Chan = 3'd6; end
        if (e == 8) Start_Req = 1'b0;
      end
      tick();
      budget++;
    end
    chk("ign_addr_stable", 32'(k), 32'd0);
    chk("ign_single_valid", 32'(seen_valid), 32'd1);
    chk("ign_data", 32'(Sample_Data), 32'h5C);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (Busy) k++;
      tick();
    end
    chk("ign_no_queued_conv", 32'(k), 32'd0);

    // Reset asserted during READ aborts the conversion
    Chan = 3'd2; AD_Data = 8'h99; Start_Req = 1'b1;
    tick();
    Start_Req = 1'b0;
    budget = 0;
    while (!AD_OE && budget < 3000) begin tick(); budget++; end
    chk("rst_read_reached", 32'(AD_OE), 32'd1);
    #2 RSTn = 1'b0;
    #1;
    chk("rst_read_oe_low", 32'(AD_OE), 32'd0);
    chk("rst_read_busy_low", 32'(Busy), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Sample_Valid) seen_valid++;
    end
    chk("rst_read_no_valid", 32'(seen_valid), 32'd0);
    run_conv(3'd4, 8'h3E);
    chk("post_rst_addr", 32'(m_addr), 32'd4);
    chk("post_rst_valid", 32'(m_valid), 32'd1);
    chk("post_rst_data", 32'(m_data), 32'h3E);
    chk("post_rst_oe_cycles", 32'(m_oe), 32'd3);

    // AD_CLK period while a conversion is running
    Chan = 3'd1; AD_Data = 8'h42; Start_Req = 1'b1;
    tick();
    Start_Req = 1'b0;
    prev_clk = AD_CLK; nrise = 0; rise0 = 0; rise1 = 0; rise2 = 0; fall1 = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (AD_CLK && !prev_clk) begin
        if (nrise == 0) rise0 = i;
        if (nrise == 1) rise1 = i;
        if (nrise == 2) rise2 = i;
        nrise++;
      end
      if (!AD_CLK && prev_clk && nrise == 2) fall1 = i;
      prev_clk = AD_CLK;
    end
    chk("adclk_period_a", 32'(rise1 - rise0), 32'd50);
    chk("adclk_period_b", 32'(rise2 - rise1), 32'd50);
    chk("adclk_high_width", 32'(fall1 - rise1), 32'd25);
    chk("adclk_conv_done", 32'(Sample_Data), 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
